// File: rtl/bra_pkg.sv
// bra_pkg: shared definitions for the branch/jump execution unit.
//   - OP_W and the op-code values carried on disp_op
//   - entry flag widths
//   - helpers: which op codes are legal, which operands each op needs
package bra_pkg;

  localparam int OP_W   = 4;
  localparam int FLAG_W = 1;

  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'd1;
  localparam logic [OP_W-1:0] OP_BNE  = 4'd2;
  localparam logic [OP_W-1:0] OP_BLT  = 4'd3;
  localparam logic [OP_W-1:0] OP_BGE  = 4'd4;
  localparam logic [OP_W-1:0] OP_BLTU = 4'd5;
  localparam logic [OP_W-1:0] OP_BGEU = 4'd6;
  localparam logic [OP_W-1:0] OP_JAL  = 4'd7;
  localparam logic [OP_W-1:0] OP_JALR = 4'd8;

  // Only BEQ..JALR occupy an entry; NOP and unknown codes are dropped.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_JALR);
  endfunction

  function automatic logic needs_a(input logic [OP_W-1:0] op);
    return op != OP_JAL;
  endfunction

  // Only the conditional branches read operand B.
  function automatic logic needs_b(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

endpackage

// File: rtl/bra_cmp.sv
// bra_cmp: combinational resolver for one branch/jump.
//   op, a, b, pc, offset -> taken, target (next PC), link (PC+4).
// All sums wrap modulo 2^XLEN.
module bra_cmp
  import bra_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [XLEN-1:0] pc_off;
  logic        [XLEN-1:0] pc_4;
  logic        [XLEN-1:0] jalr_sum;

  assign a_s      = a;
  assign b_s      = b;
  assign pc_off   = pc + offset;
  assign pc_4     = pc + XLEN'(4);
  assign jalr_sum = a + offset;
  assign link     = pc_4;

  always_comb begin
    taken  = 1'b0;
    target = pc_4;
    case (op)
      OP_NOP:          taken = 1'b0;
      OP_BEQ:          taken = (a == b);
      OP_BNE:          taken = (a != b);
      OP_BLT:          taken = (a_s < b_s);
      OP_BGE:          taken = (a_s >= b_s);
      OP_BLTU:         taken = (a < b);
      OP_BGEU:         taken = (a >= b);
      OP_JAL, OP_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
    // JALR clears bit 0 of the computed address.
    if (op == OP_JALR)
      target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (taken)
      target = pc_off;
  end

endmodule

// File: rtl/bra_station.sv
// bra_station: branch/jump execution unit with a DEPTH-entry reservation
// station, CDB operand wakeup and a registered valid/ready result stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   disp_*                dispatch request (op, operands/tags, pc, offset, dest)
//   disp_ready            at least one entry free at start of cycle
//   cdb_valid/tag/value   common data bus broadcast
//   flush                 squash all entries and the pending result
//   res_*                 registered result (taken, target, link, dest) + handshake
//   busy                  any entry occupied or result pending
module bra_station
  import bra_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_a_val,
  input  logic [XLEN-1:0]  disp_b_val,
  input  logic             disp_a_rdy,
  input  logic             disp_b_rdy,
  input  logic [ROB_W-1:0] disp_a_tag,
  input  logic [ROB_W-1:0] disp_b_tag,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [XLEN-1:0]  disp_offset,
  input  logic [ROB_W-1:0] disp_dest,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [XLEN-1:0]  res_target,
  output logic [XLEN-1:0]  res_link,
  output logic [ROB_W-1:0] res_dest,
  output logic             busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [XLEN-1:0]   a_val;
    logic [XLEN-1:0]   b_val;
    logic [FLAG_W-1:0] a_rdy;
    logic [FLAG_W-1:0] b_rdy;
    logic [ROB_W-1:0]  a_tag;
    logic [ROB_W-1:0]  b_tag;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   offset;
    logic [ROB_W-1:0]  dest;
  } ent_t;

  // Lowest-index set bit; callers qualify with |v.
  function automatic logic [IDX_W-1:0] first_set(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  logic [DEPTH-1:0] ent_vld;
  ent_t             ent [DEPTH];
  logic [DEPTH-1:0] rdy_vec;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             alloc_en;
  logic             load;
  ent_t             new_ent;
  logic             a_hit;
  logic             b_hit;
  logic             cmp_taken;
  logic [XLEN-1:0]  cmp_target;
  logic [XLEN-1:0]  cmp_link;

  logic             vld_p1;
  logic             taken_p1;
  logic [XLEN-1:0]  target_p1;
  logic [XLEN-1:0]  link_p1;
  logic [ROB_W-1:0] dest_p1;

  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy_vec[i] = ent_vld[i] & ent[i].a_rdy[0] & ent[i].b_rdy[0];
  end

  // Both encoders look at registered state only, so an entry freed by this
  // cycle's load is not reallocated until the next cycle.
  assign alloc_idx  = first_set(~ent_vld);
  assign sel_idx    = first_set(rdy_vec);
  assign disp_ready = ~&ent_vld;
  assign alloc_en   = disp_valid && disp_ready && op_legal(disp_op) && !flush;
  assign load       = (|rdy_vec) && (!vld_p1 || res_ready) && !flush;

  // Operands not yet available may be satisfied by the broadcast in the
  // dispatch cycle itself.
  assign a_hit = cdb_valid && !disp_a_rdy && (cdb_tag == disp_a_tag);
  assign b_hit = cdb_valid && !disp_b_rdy && (cdb_tag == disp_b_tag);

  always_comb begin
    new_ent        = '0;
    new_ent.op     = disp_op;
    new_ent.a_val  = disp_a_rdy ? disp_a_val : cdb_value;
    new_ent.b_val  = disp_b_rdy ? disp_b_val : cdb_value;
    new_ent.a_rdy  = FLAG_W'(disp_a_rdy || !needs_a(disp_op) || a_hit);
    new_ent.b_rdy  = FLAG_W'(disp_b_rdy || !needs_b(disp_op) || b_hit);
    new_ent.a_tag  = disp_a_tag;
    new_ent.b_tag  = disp_b_tag;
    new_ent.pc     = disp_pc;
    new_ent.offset = disp_offset;
    new_ent.dest   = disp_dest;
  end

  bra_cmp #(.XLEN(XLEN)) u_cmp (
    .op     (ent[sel_idx].op),
    .a      (ent[sel_idx].a_val),
    .b      (ent[sel_idx].b_val),
    .pc     (ent[sel_idx].pc),
    .offset (ent[sel_idx].offset),
    .taken  (cmp_taken),
    .target (cmp_target),
    .link   (cmp_link)
  );

  // ---- Stage p0: reservation-station occupancy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
    end else if (flush) begin
      ent_vld <= '0;
    end else begin
      if (load)     ent_vld[sel_idx]   <= 1'b0;
      if (alloc_en) ent_vld[alloc_idx] <= 1'b1;
    end
  end

  // Payload is qualified by ent_vld, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && !ent[i].a_rdy[0] && (ent[i].a_tag == cdb_tag)) begin
        ent[i].a_val <= cdb_value;
        ent[i].a_rdy <= FLAG_W'(1);
      end
      if (cdb_valid && !ent[i].b_rdy[0] && (ent[i].b_tag == cdb_tag)) begin
        ent[i].b_val <= cdb_value;
        ent[i].b_rdy <= FLAG_W'(1);
      end
    end
    if (alloc_en) ent[alloc_idx] <= new_ent;
  end

  // ---- Stage p1: registered result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
      link_p1   <= '0;
      dest_p1   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1    <= 1'b1;
      taken_p1  <= cmp_taken;
      target_p1 <= cmp_target;
      link_p1   <= cmp_link;
      dest_p1   <= ent[sel_idx].dest;
    end else if (res_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign res_valid  = vld_p1;
  assign res_taken  = taken_p1;
  assign res_target = target_p1;
  assign res_link   = link_p1;
  assign res_dest   = dest_p1;
  assign busy       = (|ent_vld) || vld_p1;

endmodule

// File: tb/tb_bra_station.sv
// tb_bra_station: directed and randomized bench for bra_station with a
// behavioural reference model of the reservation station and result stage.
module tb_bra_station;
  import bra_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int ROB_W = 4;

  logic             clk;
  logic             rst_n;
  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_a_val;
  logic [XLEN-1:0]  disp_b_val;
  logic             disp_a_rdy;
  logic             disp_b_rdy;
  logic [ROB_W-1:0] disp_a_tag;
  logic [ROB_W-1:0] disp_b_tag;
  logic [XLEN-1:0]  disp_pc;
  logic [XLEN-1:0]  disp_offset;
  logic [ROB_W-1:0] disp_dest;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic [XLEN-1:0]  res_target;
  logic [XLEN-1:0]  res_link;
  logic [ROB_W-1:0] res_dest;
  logic             busy;

  bra_station #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
    .disp_pc(disp_pc), .disp_offset(disp_offset), .disp_dest(disp_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_link(res_link), .res_dest(res_dest),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a bag of DEPTH slots plus one result register.
  bit              m_vld  [DEPTH];
  logic [3:0]      m_op   [DEPTH];
  logic [XLEN-1:0] m_a    [DEPTH];
  logic [XLEN-1:0] m_b    [DEPTH];
  bit              m_ardy [DEPTH];
  bit              m_brdy [DEPTH];
  logic [3:0]      m_atag [DEPTH];
  logic [3:0]      m_btag [DEPTH];
  logic [XLEN-1:0] m_pc   [DEPTH];
  logic [XLEN-1:0] m_off  [DEPTH];
  logic [3:0]      m_dest [DEPTH];
  bit              m_rv;
  bit              m_rt;
  logic [XLEN-1:0] m_rtgt;
  logic [XLEN-1:0] m_rlink;
  logic [3:0]      m_rdest;

  function automatic void resolve(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off,
                                  output bit tk, output logic [XLEN-1:0] tgt, output logic [XLEN-1:0] lnk);
    case (op)
      4'd1:       tk = (a == b);
      4'd2:       tk = (a != b);
      4'd3:       tk = ($signed(a) < $signed(b));
      4'd4:       tk = ($signed(a) >= $signed(b));
      4'd5:       tk = (a < b);
      4'd6:       tk = (a >= b);
      4'd7, 4'd8: tk = 1'b1;
      default:    tk = 1'b0;
    endcase
    lnk = pc + 32'd4;
    if (op == 4'd8)  tgt = (a + off) & ~32'h1;
    else if (tk)     tgt = pc + off;
    else             tgt = pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_rv = 1'b0; m_rt = 1'b0; m_rtgt = '0; m_rlink = '0; m_rdest = '0;
  endtask

  function automatic bit m_any_free();
    for (int i = 0; i < DEPTH; i++) if (!m_vld[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < DEPTH; i++) if (m_vld[i]) return 1'b1;
    return m_rv;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int sel;
    int fr;
    bit acc;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      m_rv = 1'b0;
      return;
    end
    sel = -1;
    fr  = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel < 0 && m_vld[i] && m_ardy[i] && m_brdy[i]) sel = i;
      if (fr < 0 && !m_vld[i]) fr = i;
    end
    acc = disp_valid && (fr >= 0) && (disp_op >= 4'd1) && (disp_op <= 4'd8);
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_vld[i] && !m_ardy[i] && m_atag[i] == cdb_tag) begin m_a[i] = cdb_value; m_ardy[i] = 1'b1; end
        if (m_vld[i] && !m_brdy[i] && m_btag[i] == cdb_tag) begin m_b[i] = cdb_value; m_brdy[i] = 1'b1; end
      end
    end
    if (sel >= 0 && (!m_rv || res_ready)) begin
      resolve(m_op[sel], m_a[sel], m_b[sel], m_pc[sel], m_off[sel], m_rt, m_rtgt, m_rlink);
      m_rdest    = m_dest[sel];
      m_rv       = 1'b1;
      m_vld[sel] = 1'b0;
    end else if (res_ready) begin
      m_rv = 1'b0;
    end
    if (acc) begin
      m_vld[fr]  = 1'b1;
      m_op[fr]   = disp_op;
      m_ardy[fr] = disp_a_rdy || (disp_op == 4'd7) || (cdb_valid && cdb_tag == disp_a_tag);
      m_brdy[fr] = disp_b_rdy || (disp_op > 4'd6) || (cdb_valid && cdb_tag == disp_b_tag);
      m_a[fr]    = disp_a_rdy ? disp_a_val : cdb_value;
      m_b[fr]    = disp_b_rdy ? disp_b_val : cdb_value;
      m_atag[fr] = disp_a_tag;
      m_btag[fr] = disp_b_tag;
      m_pc[fr]   = disp_pc;
      m_off[fr]  = disp_offset;
      m_dest[fr] = disp_dest;
    end
  endtask

  task automatic check_all();
    check("disp_ready", 32'(disp_ready), 32'(m_any_free()));
    check("busy",       32'(busy),       32'(m_busy()));
    check("res_valid",  32'(res_valid),  32'(m_rv));
    check("res_taken",  32'(res_taken),  32'(m_rt));
    check("res_target", res_target,      m_rtgt);
    check("res_link",   res_link,        m_rlink);
    check("res_dest",   32'(res_dest),   32'(m_rdest));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [XLEN-1:0] a, input logic ar, input logic [3:0] at,
                      input logic [XLEN-1:0] b, input logic br, input logic [3:0] bt,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off, input logic [3:0] dest);
    disp_valid = 1'b1; disp_op = op;
    disp_a_val = a; disp_a_rdy = ar; disp_a_tag = at;
    disp_b_val = b; disp_b_rdy = br; disp_b_tag = bt;
    disp_pc = pc; disp_offset = off; disp_dest = dest;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp_ready"}, 32'(disp_ready), 32'd1);
    check({tag, "_res_valid"},  32'(res_valid),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_res_taken"},  32'(res_taken),  32'd0);
    check({tag, "_res_target"}, res_target,      32'd0);
    check({tag, "_res_link"},   res_link,        32'd0);
    check({tag, "_res_dest"},   32'(res_dest),   32'd0);
  endtask

  logic [3:0] drain_order [DEPTH];

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; res_ready = 1'b1;
    idle();
    disp(OP_NOP, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, '0, 4'd0);
    disp_valid = 1'b0;
    cdb_tag = '0; cdb_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic BEQ: result two edges after dispatch.
    disp(OP_BEQ, 32'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'h100, 32'h20, 4'd1);
    tick();
    idle();
    tick();
    check("beq_valid",  32'(res_valid), 32'd1);
    check("beq_taken",  32'(res_taken), 32'd1);
    check("beq_target", res_target, 32'h120);
    check("beq_link",   res_link,   32'h104);
    tick();

    // Signed vs unsigned compare, JALR alignment; back-to-back results.
    disp(OP_BLT, 32'hFFFF_FFFF, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'h200, 32'h40, 4'd2);
    tick();
    disp(OP_BLTU, 32'hFFFF_FFFF, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'h200, 32'h40, 4'd3);
    tick();
    check("blt_taken",  32'(res_taken), 32'd1);
    check("blt_target", res_target, 32'h240);
    disp(OP_JALR, 32'h1001, 1'b1, 4'd0, 32'd0, 1'b0, 4'd0, 32'h300, 32'd2, 4'd4);
    tick();
    check("bltu_taken",  32'(res_taken), 32'd0);
    check("bltu_target", res_target, 32'h204);
    idle();
    tick();
    check("jalr_valid",  32'(res_valid), 32'd1);
    check("jalr_target", res_target, 32'h1002);
    check("jalr_link",   res_link,   32'h304);
    tick();

    // CDB wakeup three cycles after dispatch.
    disp(OP_BNE, 32'd0, 1'b0, 4'd3, 32'd9, 1'b1, 4'd0, 32'h400, 32'h10, 4'd5);
    tick();
    idle();
    tick();
    tick();
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'd7;
    tick();
    check("wake_not_yet", 32'(res_valid), 32'd0);
    idle();
    tick();
    check("wake_valid",  32'(res_valid), 32'd1);
    check("wake_taken",  32'(res_taken), 32'd1);
    check("wake_target", res_target, 32'h410);
    tick();

    // Bypass: broadcast in the dispatch cycle; A captures 7, so BNE vs 7 falls through.
    disp(OP_BNE, 32'd0, 1'b0, 4'd3, 32'd7, 1'b1, 4'd0, 32'h500, 32'h10, 4'd6);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'd7;
    tick();
    idle();
    tick();
    check("byp_valid",  32'(res_valid), 32'd1);
    check("byp_taken",  32'(res_taken), 32'd0);
    check("byp_target", res_target, 32'h504);
    tick();

    // Backpressure: DEPTH+1 ready branches with the consumer stalled.
    res_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      disp(OP_BEQ, 32'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'h1000 + 32'(k * 16), 32'h100, 4'(k));
      tick();
      if (k >= 1) begin
        check("hold_dest",   32'(res_dest), 32'd0);
        check("hold_target", res_target, 32'h1100);
      end
    end
    idle();
    check("full_disp_ready", 32'(disp_ready), 32'd0);
    tick();
    check("held_valid", 32'(res_valid), 32'd1);
    check("held_dest",  32'(res_dest), 32'd0);
    res_ready = 1'b1;
    // Entries hold dests {2,1,3,4} in index order 0..3.
    drain_order[0] = 4'd2; drain_order[1] = 4'd1; drain_order[2] = 4'd3; drain_order[3] = 4'd4;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check("drain_valid", 32'(res_valid), 32'd1);
      check("drain_dest",  32'(res_dest), 32'(drain_order[k]));
    end
    tick();
    check("drain_empty", 32'(busy), 32'd0);

    // Flush with three entries and a pending result, plus a dispatch.
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(OP_BGE, 32'd3, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'h2000, 32'h8, 4'(8 + k));
      tick();
    end
    idle();
    check("pre_flush_valid", 32'(res_valid), 32'd1);
    flush = 1'b1;
    disp(OP_BEQ, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'h3000, 32'h8, 4'd12);
    tick();
    idle();
    check("flush_valid", 32'(res_valid), 32'd0);
    check("flush_busy",  32'(busy), 32'd0);
    check("flush_ready", 32'(disp_ready), 32'd1);
    tick();
    check("flush_noalloc", 32'(busy), 32'd0);

    // Asynchronous reset between edges with pending work.
    disp(OP_JAL, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'h4000, 32'h40, 4'd13);
    tick();
    disp(OP_BEQ, 32'd0, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'h4100, 32'h40, 4'd14);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    #2 rst_n = 1'b1;
    res_ready = 1'b1;
    disp(OP_NOP, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'h10, 32'h4, 4'd1);
    tick();
    check("op0_busy", 32'(busy), 32'd0);
    disp(4'd9, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'h10, 32'h4, 4'd1);
    tick();
    check("op9_busy", 32'(busy), 32'd0);
    idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [XLEN-1:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 3)) - 32'd2;
      flush     = ($urandom_range(0, 39) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      disp($urandom_range(0, 9) > 0 ? 4'($urandom_range(0, 9)) : 4'd0,
           ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0) ? ra : (($urandom_range(0, 1) == 0) ? ~ra : 32'($urandom)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           32'($urandom), 32'($urandom), 4'($urandom_range(0, 15)));
      disp_valid = ($urandom_range(0, 2) != 0);
      cdb_valid  = ($urandom_range(0, 1) == 1);
      cdb_tag    = 4'($urandom_range(0, 3));
      cdb_value  = ($urandom_range(0, 1) == 1) ? ra : 32'($urandom);
      tick();
    end
    idle();
    flush = 1'b1;
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bra_station.md
# bra_station

Parametrised branch/jump execution unit for the out-of-order core. It replaces the single-operation combinational branch resolver with three things:

- a `DEPTH`-entry reservation station that wakes operands from the CDB;
- a wider op set: signed/unsigned compares, JAL, JALR;
- a registered result stage with a valid/ready handshake to the CDB/ROB arbiter.

It sits between dispatch and the ROB and reports `taken`, `target` and the link value per ROB tag.

## Interface
Parameters:
- `XLEN`, 32, operand/PC width
- `DEPTH`, 4, reservation-station entries (≥2)
- `ROB_W`, 4, ROB tag width

Ports (reset is asynchronous and active-low):
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `disp_valid` in 1, dispatch request
- `disp_ready` out 1, at least one free entry
- `disp_op` in 4, op code (`bra_pkg`)
- `disp_a_val` / `disp_b_val` in XLEN, operand value when ready
- `disp_a_rdy` / `disp_b_rdy` in 1, operand already available
- `disp_a_tag` / `disp_b_tag` in ROB_W, producer tag when not ready
- `disp_pc` in XLEN, instruction PC
- `disp_offset` in XLEN, sign-extended immediate
- `disp_dest` in ROB_W, ROB entry of this instruction
- `cdb_valid` in 1, broadcast valid
- `cdb_tag` in ROB_W, broadcast tag
- `cdb_value` in XLEN, broadcast value
- `flush` in 1, squash all state
- `res_valid` out 1, result available
- `res_ready` in 1, consumer accepts
- `res_taken` out 1, branch taken (always 1 for JAL/JALR)
- `res_target` out XLEN, next PC
- `res_link` out XLEN, PC+4
- `res_dest` out ROB_W, ROB tag
- `busy` out 1, any entry occupied or `res_valid`

## Operation
- **Ops:**
  - NOP=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6, JAL=7, JALR=8.
  - Dispatch of an op outside 1–8 allocates nothing.
- **Operand needs:**
  - JAL needs no operands.
  - JALR needs A only.
  - Branches need A and B.
  - Unneeded operands are treated as ready.
- **Allocation:**
  - A dispatch is accepted when `disp_valid && disp_ready`.
  - The lowest-index free entry is written.
  - `disp_ready` reflects free entries at the start of the cycle; an entry freed in the same cycle does not count.
- **Wakeup:**
  - Each not-ready operand whose tag equals `cdb_tag` while `cdb_valid` captures `cdb_value` and becomes ready.
  - This also applies to an operand being dispatched in the same cycle (bypass).
  - Already-ready operands ignore the CDB.
- **Select:** the lowest-index entry with all needed operands ready.
- **Result stage:**
  - Loads when `!res_valid || res_ready`.
  - Loading frees the selected entry.
- **Resolve:**
  - Branch taken → `target = PC+offset`; not taken → `target = PC+4`.
  - JAL: `target = PC+offset`.
  - JALR: `target = (A+offset) & ~1`.
  - `res_link = PC+4` for all ops.
  - Arithmetic is modulo 2^XLEN.
  - BLT/BGE compare signed; BLTU/BGEU compare unsigned.
- **Flush:**
  - The next edge clears all entries and `res_valid`.
  - Flush dominates same-cycle dispatch, wakeup and result load.
- **Reset values:**
  - All entries free; `res_valid=0`; `busy=0`; `disp_ready=1`.
  - `res_taken=0`; `res_target`, `res_link`, `res_dest` = 0.

## Timing
- **Latency:** dispatch with operands ready at edge E0 → entry selected and result loaded at E1 → `res_valid` high after E1.
- **CDB wakeup:** CDB at edge E0 wakes an entry → result loaded at E1.
- **Handshake:**
  - The result is held stable while `res_valid && !res_ready`.
  - While held, no new load occurs and entries fill; `disp_ready` drops when all `DEPTH` entries are occupied.
- **Back-to-back:** with `res_ready` held high, one result per cycle.
- **Reset:** `rst_n` low mid-operation clears everything immediately, independent of `clk`.

## Structure
- **`bra_pkg`:**
  - Op-code localparams.
  - `OP_W=4`.
  - Entry struct/field widths: valid, op, a/b value, a/b ready, a/b tag, pc, offset, dest.
- **Sub-module `bra_cmp`:**
  - Combinational: op, A, B, PC, offset → taken, target, link.
  - Used once, on the selected entry.
- **Top level:** entry array, allocate/select priority encoders, wakeup, and the output register.

## Test plan
1. **Reset:** after reset, `disp_ready=1`, `res_valid=0`, `busy=0`. Dispatch BEQ, A=B=5, PC=0x100, off=0x20, `res_ready=1` → two edges later `res_taken=1`, `target=0x120`, `link=0x104`.
2. **Signed vs unsigned:** BLT A=0xFFFFFFFF, B=1 → taken. BLTU with the same operands → not taken, `target=PC+4`. JALR A=0x1001, off=2 → `target=0x1002`.
3. **Wakeup:**
   - Dispatch BNE with A waiting on tag 3; CDB tag 3, value 7 arrives three cycles later (B=9) → result one edge after the CDB, taken.
   - CDB tag 3 in the dispatch cycle itself → captured via bypass.
4. **Backpressure:**
   - Hold `res_ready=0` and dispatch DEPTH+1 ready branches → first result held stable, `disp_ready=0` once full.
   - Raise `res_ready` → results drain one per cycle in index order.
5. **Flush:** flush with 3 occupied entries and `res_valid=1`, plus a simultaneous dispatch → next cycle `res_valid=0`, `busy=0`, nothing allocated.
6. **Async reset:** assert `rst_n` low mid-cycle with pending entries → outputs return to reset values before the next edge. A dispatch with op 0 or 9 → no allocation, `busy` stays 0.
